// File: rtl/sort_pkg.sv
// Shared types for the odd-even transposition sorter.
// FSM state encoding and sort-direction constants.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SORT = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic MODE_ASC  = 1'b0;
  localparam logic MODE_DESC = 1'b1;

endpackage

// File: rtl/sort_cmp_swap.sv
// Combinational compare-exchange cell carrying an index with its value.
// Strict comparison keeps equal values in their original order.
module sort_cmp_swap
  import sort_pkg::*;
#(
  parameter int W  = 16,
  parameter int IW = 4
) (
  input  logic signed [W-1:0]  a_val,
  input  logic        [IW-1:0] a_idx,
  input  logic signed [W-1:0]  b_val,
  input  logic        [IW-1:0] b_idx,
  input  logic                 mode,
  input  logic                 en,
  output logic signed [W-1:0]  lo_val,
  output logic        [IW-1:0] lo_idx,
  output logic signed [W-1:0]  hi_val,
  output logic        [IW-1:0] hi_idx,
  output logic                 swap
);

  logic gt;
  logic lt;

  assign gt   = a_val > b_val;
  assign lt   = a_val < b_val;
  assign swap = en & ((mode == MODE_DESC) ? lt : gt);

  assign lo_val = swap ? b_val : a_val;
  assign lo_idx = swap ? b_idx : a_idx;
  assign hi_val = swap ? a_val : b_val;
  assign hi_idx = swap ? a_idx : b_idx;

endmodule

// File: rtl/param_oet_sorter.sv
// Parametrised odd-even transposition sorter with index tracking,
// early termination and a valid/ready interface on both sides.
module param_oet_sorter
  import sort_pkg::*;
#(
  parameter  int N  = 10,
  parameter  int W  = 16,
  localparam int IW = $clog2(N),
  localparam int CW = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  in_data,
  input  logic            in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*W-1:0]  out_data,
  output logic [N*IW-1:0] out_index,
  output logic [IW-1:0]   max_index,
  output logic [CW-1:0]   sort_cycles,
  output logic            busy
);

  state_t state_q;
  state_t state_d;

  logic signed [W-1:0]  val_q [N];
  logic signed [W-1:0]  val_d [N];
  logic        [IW-1:0] idx_q [N];
  logic        [IW-1:0] idx_d [N];

  logic          mode_q;
  logic [CW-1:0] ph_q;
  logic          swap_prev_q;
  logic [CW-1:0] cycles_q;
  logic [IW-1:0] max_q;

  logic signed [W-1:0]  lo_v [N-1];
  logic signed [W-1:0]  hi_v [N-1];
  logic        [IW-1:0] lo_i [N-1];
  logic        [IW-1:0] hi_i [N-1];
  logic        [N-2:0]  en;
  logic        [N-2:0]  sw;

  logic accept;
  logic swap_now;
  logic sort_end;

  assign in_ready  = (state_q == IDLE) ||
                     (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SORT);
  assign swap_now  = |sw;

  // Two swap-free phases in a row mean every pair is in order.
  assign sort_end = (ph_q == CW'(N - 1)) ||
                    (ph_q != '0 && !swap_now && !swap_prev_q);

  for (genvar j = 0; j < N - 1; j++) begin : g_pair
    if (j % 2 == 0) begin : g_even
      assign en[j] = ~ph_q[0];
    end else begin : g_odd
      assign en[j] = ph_q[0];
    end

    sort_cmp_swap #(
      .W (W),
      .IW(IW)
    ) u_cs (
      .a_val (val_q[j]),
      .a_idx (idx_q[j]),
      .b_val (val_q[j+1]),
      .b_idx (idx_q[j+1]),
      .mode  (mode_q),
      .en    (en[j]),
      .lo_val(lo_v[j]),
      .lo_idx(lo_i[j]),
      .hi_val(hi_v[j]),
      .hi_idx(hi_i[j]),
      .swap  (sw[j])
    );
  end

  // At most one of the two pairs touching a slot is enabled per phase.
  for (genvar p = 0; p < N; p++) begin : g_pos
    if (p == 0) begin : g_first
      assign val_d[p] = en[p] ? lo_v[p] : val_q[p];
      assign idx_d[p] = en[p] ? lo_i[p] : idx_q[p];
    end else if (p == N - 1) begin : g_last
      assign val_d[p] = en[p-1] ? hi_v[p-1] : val_q[p];
      assign idx_d[p] = en[p-1] ? hi_i[p-1] : idx_q[p];
    end else begin : g_mid
      assign val_d[p] = en[p]   ? lo_v[p]   :
                        en[p-1] ? hi_v[p-1] : val_q[p];
      assign idx_d[p] = en[p]   ? lo_i[p]   :
                        en[p-1] ? hi_i[p-1] : idx_q[p];
    end
    assign out_data[p*W +: W]    = val_q[p];
    assign out_index[p*IW +: IW] = idx_q[p];
  end

  assign max_index   = max_q;
  assign sort_cycles = cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = SORT;
      SORT: if (sort_end) state_d = DONE;
      DONE: begin
        if (accept)         state_d = SORT;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        val_q[i] <= '0;
        idx_q[i] <= '0;
      end
      mode_q      <= MODE_ASC;
      ph_q        <= '0;
      swap_prev_q <= 1'b0;
      cycles_q    <= '0;
      max_q       <= '0;
    end else if (accept) begin
      for (int i = 0; i < N; i++) begin
        val_q[i] <= in_data[i*W +: W];
        idx_q[i] <= IW'(i);
      end
      mode_q      <= in_mode;
      ph_q        <= '0;
      swap_prev_q <= 1'b0;
    end else if (state_q == SORT) begin
      for (int i = 0; i < N; i++) begin
        val_q[i] <= val_d[i];
        idx_q[i] <= idx_d[i];
      end
      ph_q        <= ph_q + CW'(1);
      swap_prev_q <= swap_now;
      if (sort_end) begin
        cycles_q <= ph_q + CW'(1);
        max_q    <= (mode_q == MODE_DESC) ? idx_d[0] : idx_d[N-1];
      end
    end
  end

endmodule
